// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - shared traffic-light state encodings and default timer intervals
//
// Used by both the next-state logic and the interval timer so that both
// ends of the TS/TL interface agree on the state encoding.
//   S0..S3      : 2-bit state encodings
//   tl_state_t  : current-state bus type
//   SHORT_T_DEF : default short interval in ticks
//   LONG_T_DEF  : default long interval in ticks
package tl_pkg;

    typedef logic [1:0] tl_state_t;

    localparam tl_state_t S0 = 2'b00;
    localparam tl_state_t S1 = 2'b01;
    localparam tl_state_t S2 = 2'b10;
    localparam tl_state_t S3 = 2'b11;

    localparam int SHORT_T_DEF = 5;
    localparam int LONG_T_DEF  = 25;

endpackage

// File: rtl/tl_interval_timer_if.sv
// rtl/tl_interval_timer_if.sv - controller <-> interval timer signal bundle
//
// Optional macro: TL_TIMER_HOLD_EN adds Hold_i (count freeze).
//   State_i   : controller registered current state (controller -> timer)
//   Restart_i : forced synchronous restart          (controller -> timer)
//   Tick_i    : one-cycle prescaler count enable    (controller -> timer)
//   Hold_i    : freeze counting (only with TL_TIMER_HOLD_EN)
//   TS_o      : short interval elapsed, level        (timer -> controller)
//   TL_o      : long interval elapsed, level         (timer -> controller)
//   Count_o   : current tick count, debug/status     (timer -> controller)
// Modports: master = controller side, slave = timer side.
interface tl_interval_timer_if
    import tl_pkg::*;
#(
    parameter int CNT_W = 8
);

    tl_state_t          State_i;
    logic               Restart_i;
    logic               Tick_i;
`ifdef TL_TIMER_HOLD_EN
    logic               Hold_i;
`endif
    logic               TS_o;
    logic               TL_o;
    logic [CNT_W-1:0]   Count_o;

`ifdef TL_TIMER_HOLD_EN
    modport master (output State_i, Restart_i, Tick_i, Hold_i,
                    input  TS_o, TL_o, Count_o);
    modport slave  (input  State_i, Restart_i, Tick_i, Hold_i,
                    output TS_o, TL_o, Count_o);
`else
    modport master (output State_i, Restart_i, Tick_i,
                    input  TS_o, TL_o, Count_o);
    modport slave  (input  State_i, Restart_i, Tick_i,
                    output TS_o, TL_o, Count_o);
`endif

endinterface

// File: rtl/tl_interval_timer.sv
// rtl/tl_interval_timer.sv - TS/TL interval timer restarted on every controller state change
//
// Optional macro: TL_TIMER_HOLD_EN (Hold_i freezes the tick counter).
// Ports:
//   Clk_i  : system clock, rising edge
//   nRst_i : asynchronous active-low reset
//   bus    : tl_interval_timer_if.slave (State_i, Restart_i, Tick_i,
//            [Hold_i], TS_o, TL_o, Count_o)
// Parameters:
//   CNT_W   : counter width
//   SHORT_T : ticks until TS_o asserts (1 <= SHORT_T < LONG_T)
//   LONG_T  : ticks until TL_o asserts (LONG_T <= 2^CNT_W - 1)
module tl_interval_timer
    import tl_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int SHORT_T = SHORT_T_DEF,
    parameter int LONG_T  = LONG_T_DEF
) (
    input  logic                    Clk_i,
    input  logic                    nRst_i,
    tl_interval_timer_if.slave      bus
);

    localparam logic [CNT_W-1:0] SHORT_C = CNT_W'(SHORT_T);
    localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_T);

    tl_state_t          PrevState_r;
    logic [CNT_W-1:0]   Count_r;
    logic               restart;
    logic               count_en;

    // A state change or a forced restart both mean "new phase starts now";
    // the two together are still just one restart.
    assign restart = (bus.State_i != PrevState_r) | bus.Restart_i;

`ifdef TL_TIMER_HOLD_EN
    assign count_en = bus.Tick_i & ~bus.Hold_i;
`else
    assign count_en = bus.Tick_i;
`endif

    always_ff @(posedge Clk_i or negedge nRst_i) begin
        if (!nRst_i) begin
            PrevState_r <= S0;
            Count_r     <= '0;
        end else begin
            PrevState_r <= bus.State_i;
            if (restart) begin
                Count_r <= '0;
            end else if (count_en && (Count_r < LONG_C)) begin
                Count_r <= Count_r + 1'b1;
            end
        end
    end

    // Flags are masked in the first cycle of a new phase so stale elapsed
    // flags from the previous phase cannot make the controller skip a state.
    assign bus.TS_o    = (Count_r >= SHORT_C) & ~restart;
    assign bus.TL_o    = (Count_r >= LONG_C)  & ~restart;
    assign bus.Count_o = Count_r;

endmodule

// File: tb/tb_tl_interval_timer.sv
// tb/tb_tl_interval_timer.sv - directed self-checking bench for tl_interval_timer
module tb_tl_interval_timer;
    import tl_pkg::*;

    localparam int CNT_W = 8;

    logic Clk_i;
    logic nRst_i;
    int   tests;
    int   failed;

    tl_interval_timer_if #(.CNT_W(CNT_W)) bus ();

    tl_interval_timer #(
        .CNT_W   (CNT_W),
        .SHORT_T (3),
        .LONG_T  (6)
    ) dut (
        .Clk_i  (Clk_i),
        .nRst_i (nRst_i),
        .bus    (bus.slave)
    );

    initial Clk_i = 1'b0;
    always #5 Clk_i = ~Clk_i;

    task automatic step(input int n);
        repeat (n) @(posedge Clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int cnt, input logic ts, input logic tl);
        check({tag, ".count"}, 32'(bus.Count_o), 32'(cnt));
        check({tag, ".ts"},    32'(bus.TS_o),    32'(ts));
        check({tag, ".tl"},    32'(bus.TL_o),    32'(tl));
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        nRst_i        = 1'b0;
        bus.State_i   = S0;
        bus.Restart_i = 1'b0;
        bus.Tick_i    = 1'b1;
`ifdef TL_TIMER_HOLD_EN
        bus.Hold_i    = 1'b0;
`endif

        // Reset holds everything clear even with ticks present.
        step(2);
        check_all("reset", 0, 1'b0, 1'b0);

        // Free-run from S0 with Tick tied high.
        nRst_i = 1'b1;
        step(2);
        check_all("run2", 2, 1'b0, 1'b0);
        step(1);
        check_all("run3", 3, 1'b1, 1'b0);
        step(2);
        check_all("run5", 5, 1'b1, 1'b0);
        step(1);
        check_all("run6", 6, 1'b1, 1'b1);
        step(2);
        check_all("sat", 6, 1'b1, 1'b1);

        // State change masks stale flags in the change cycle.
        bus.State_i = S1;
        #1;
        check_all("chg_cycle", 6, 1'b0, 1'b0);
        step(1);
        check_all("chg_edge", 0, 1'b0, 1'b0);
        step(2);
        check_all("chg2", 2, 1'b0, 1'b0);
        step(1);
        check_all("chg3", 3, 1'b1, 1'b0);

        // Sparse ticks, one every 4th clock.
        bus.Restart_i = 1'b1;
        step(1);
        check("sparse_rst.count", 32'(bus.Count_o), 0);
        bus.Restart_i = 1'b0;
        bus.Tick_i    = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step(3);
            bus.Tick_i = 1'b1;
            step(1);
            bus.Tick_i = 1'b0;
            if (k == 2) check_all("sparse_t2", 2, 1'b0, 1'b0);
            if (k == 3) check_all("sparse_t3", 3, 1'b1, 1'b0);
            if (k == 5) check_all("sparse_t5", 5, 1'b1, 1'b0);
            if (k == 6) check_all("sparse_t6", 6, 1'b1, 1'b1);
        end
        step(3);
        check_all("sparse_hold", 6, 1'b1, 1'b1);

        // Restart together with Tick goes to 0, not 1.
        bus.Restart_i = 1'b1;
        bus.Tick_i    = 1'b1;
        step(1);
        bus.Restart_i = 1'b0;
        step(5);
        check_all("pre_rt", 5, 1'b1, 1'b0);
        bus.Restart_i = 1'b1;
        #1;
        check_all("rt_cycle", 5, 1'b0, 1'b0);
        step(1);
        check_all("rt_edge", 0, 1'b0, 1'b0);
        bus.Restart_i = 1'b0;

        // Asynchronous reset mid-cycle at count 4.
        step(4);
        check("pre_arst.count", 32'(bus.Count_o), 4);
        #2;
        nRst_i      = 1'b0;
        bus.State_i = S0;
        #1;
        check_all("arst", 0, 1'b0, 1'b0);
        nRst_i = 1'b1;
        step(1);
        check_all("post_arst1", 1, 1'b0, 1'b0);
        step(2);
        check_all("post_arst3", 3, 1'b1, 1'b0);

`ifdef TL_TIMER_HOLD_EN
        // Hold freezes counting; restart still clears while held.
        bus.Restart_i = 1'b1;
        step(1);
        bus.Restart_i = 1'b0;
        step(2);
        check("hold_pre.count", 32'(bus.Count_o), 2);
        bus.Hold_i = 1'b1;
        step(10);
        check_all("held", 2, 1'b0, 1'b0);
        bus.Hold_i = 1'b0;
        step(1);
        check_all("unheld1", 3, 1'b1, 1'b0);
        bus.Hold_i    = 1'b1;
        bus.Restart_i = 1'b1;
        step(1);
        bus.Restart_i = 1'b0;
        check_all("held_rst", 0, 1'b0, 1'b0);
        bus.Hold_i = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
